ysyx_22050133_axi_arbiter: RTL
==============================

YSYX_22050133_AXI_ARBITER -- requirements
Module: ysyx_22050133_axi_arbiter

Interface
REQ-001 SHALL have parameter IF_LEN, default 8'd3, burst length-1 (AXI len encoding) for instruction refills.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset.
- if_valid_i  in  1  instruction refill request.
- if_ready_o  out  1  refill request accepted.
- if_addr_i  in  32  refill address, 8-byte aligned.
- if_rvalid_o  out  1  refill beat valid.
- if_rdata_o  out  64  refill beat data.
- ls_valid_i  in  1  load/store request.
- ls_ready_o  out  1  load/store request accepted.
- ls_addr_i  in  32  load/store address.
- ls_we_i  in  1  1 = store.
- ls_size_i  in  3  AXI size encoding.
- ls_wdata_i  in  64  store data, unshifted.
- ls_done_o  out  1  load data valid or store complete.
- ls_rdata_o  out  64  load data, right-aligned.
- m_addr_valid_o / m_addr_ready_i  out/in  1  master request handshake.
- m_addr_o  out  32  master address.
- m_we_o  out  1  master write enable.
- m_len_o  out  8  master burst length-1.
- m_size_o  out  3  master size.
- m_burst_o  out  2  master burst; constant INCR (2'b01).
- m_wvalid_o / m_wready_i  out/in  1  master write-data handshake.
- m_wdata_o  out  64  master write data.
- m_rvalid_i / m_rready_o  in/out  1  master read-data handshake.
- m_rdata_i  in  64  master read data.
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM IDLE, ADDR, WDATA, WRESP, RDATA, with a registered owner flag (IF or LS).
REQ-005 IDLE: on any valid, SHALL grant one requester and register its address, we, len, size and wdata. IF: we=0, len=IF_LEN, size=3'b011. LS: len=0. SHALL pulse the grantee's *_ready_o for exactly that cycle, then go to ADDR.
REQ-006 Requesters SHALL hold valid and payload stable until ready; the non-granted requester stays pending.
REQ-007 ADDR: m_addr_valid_o=1 with registered fields. On m_addr_valid_o&m_addr_ready_i, go to WDATA if we, else RDATA.
REQ-008 WDATA: m_wvalid_o=1, m_wdata_o=registered data. On handshake, go to WRESP.
REQ-009 WRESP: wait for the first cycle with m_addr_ready_i=1 (master write idle after B); in that cycle pulse ls_done_o=1 for one cycle, then go to IDLE.
REQ-010 RDATA: m_rready_o=1; count beats (8-bit counter, cleared on entry). Each beat SHALL pass combinationally to the owner: if_rvalid_o/if_rdata_o or ls_done_o/ls_rdata_o.
REQ-011 RDATA SHALL exit to IDLE on the beat where count==registered len; an LS read completes on its single beat.
REQ-012 Back-to-back transactions SHALL have exactly one IDLE cycle between them; no request is issued while not in IDLE.
REQ-013 m_addr_valid_o, m_wvalid_o and m_rready_o SHALL be mutually exclusive; the *_valid_o/done outputs of the non-owner SHALL stay 0.
REQ-014 Simultaneous if_valid_i and ls_valid_i in IDLE SHALL be resolved per REQ-017.

Reset
REQ-015 rst SHALL force IDLE, owner=LS, beat counter 0, all registered payloads 0 and all outputs 0 except m_burst_o=2'b01; this takes effect on the next edge, including mid-burst.
REQ-016 After reset, outstanding requests SHALL be re-arbitrated from IDLE; the master shares rst, so no beats are drained.

Configuration
REQ-017 Macro YSYX_22050133_ARB_RR_EN:
- Defined: round-robin; on a tie, grant the requester not granted last (last-grant flag resets to LS, so IF wins the first tie).
- Undefined: fixed priority; LS always wins ties.

Verification
REQ-018 The bench SHALL cover:
- LS load, addr 0x80000004, size 2, m_rdata_i 0x1234: one m_addr handshake with len 0, then ls_done_o=1 with ls_rdata_o=0x1234; back in IDLE one cycle later.
- IF refill, addr 0x80000000, IF_LEN=3: m_len_o=3, exactly 4 if_rvalid_o pulses in order, no ls_done_o.
- LS store, addr 0x80001000, data 0xAB: m_we_o=1, m_wdata_o=0xAB, then ls_done_o only after m_addr_ready_i returns to 1.
- Tie, both valid in the same cycle, repeated twice: RR_EN gives IF, LS, IF, LS; without it, LS then IF after LS drops valid.
- rst asserted on RDATA beat 2 of 4: next cycle IDLE with all outputs 0; a held request is re-granted after rst deasserts.

Source files
------------

// File: rtl/ysyx_22050133_axi_arbiter.sv
// ysyx_22050133_axi_arbiter
//
// Shares one AXI-like master port between the instruction-refill requester
// (IF) and the load/store requester (LS). One transaction is in flight at a
// time. The winner's request is latched in IDLE, then the FSM walks
// ADDR -> (WDATA -> WRESP | RDATA) -> IDLE.
//
// Tie-break when both requesters are valid in the same IDLE cycle:
//   YSYX_22050133_ARB_RR_EN defined   : round-robin. The requester that was
//                                       not granted last wins. After reset the
//                                       last grant counts as LS, so IF wins the
//                                       first tie.
//   YSYX_22050133_ARB_RR_EN undefined : fixed priority. LS always wins.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   if_valid_i / if_ready_o    refill request handshake, if_addr_i 8B aligned
//   if_rvalid_o / if_rdata_o   refill beats (IF_LEN+1 of them)
//   ls_valid_i / ls_ready_o    load/store request handshake
//   ls_addr_i, ls_we_i, ls_size_i, ls_wdata_i   load/store payload
//   ls_done_o / ls_rdata_o     load data valid or store complete
//   m_addr_valid_o / m_addr_ready_i, m_addr_o, m_we_o, m_len_o, m_size_o,
//   m_burst_o                  master request channel
//   m_wvalid_o / m_wready_i, m_wdata_o           master write data
//   m_rvalid_i / m_rready_o, m_rdata_i           master read data
module ysyx_22050133_axi_arbiter #(
  parameter logic [7:0] IF_LEN = 8'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] if_addr_i,
  output logic        if_rvalid_o,
  output logic [63:0] if_rdata_o,
  input  logic        ls_valid_i,
  output logic        ls_ready_o,
  input  logic [31:0] ls_addr_i,
  input  logic        ls_we_i,
  input  logic [2:0]  ls_size_i,
  input  logic [63:0] ls_wdata_i,
  output logic        ls_done_o,
  output logic [63:0] ls_rdata_o,
  output logic        m_addr_valid_o,
  input  logic        m_addr_ready_i,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [7:0]  m_len_o,
  output logic [2:0]  m_size_o,
  output logic [1:0]  m_burst_o,
  output logic        m_wvalid_o,
  input  logic        m_wready_i,
  output logic [63:0] m_wdata_o,
  input  logic        m_rvalid_i,
  output logic        m_rready_o,
  input  logic [63:0] m_rdata_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRESP = 3'd3,
    RDATA = 3'd4
  } state_e;

  state_e      state_q;
  logic        owner_if_q;   // 1 = IF owns the bus, 0 = LS; also the last grant
  logic [31:0] addr_q;
  logic        we_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [63:0] wdata_q;
  logic [7:0]  cnt_q;

  logic tie_if;
  logic grant_if;
  logic grant_ls;
  logic beat;
  logic ls_rd_done;

`ifdef YSYX_22050133_ARB_RR_EN
  assign tie_if = ~owner_if_q;
`else
  assign tie_if = 1'b0;
`endif

  // A grant while rst is high would be lost on the reset edge, so the
  // requester must not see ready then; it keeps valid and is re-arbitrated.
  assign grant_if = (state_q == IDLE) & ~rst & if_valid_i & (~ls_valid_i | tie_if);
  assign grant_ls = (state_q == IDLE) & ~rst & ls_valid_i & ~grant_if;

  assign beat = (state_q == RDATA) & m_rvalid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_if_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      len_q      <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_if) begin
            owner_if_q <= 1'b1;
            addr_q     <= if_addr_i;
            we_q       <= 1'b0;
            len_q      <= IF_LEN;
            size_q     <= 3'b011;
            wdata_q    <= '0;
            state_q    <= ADDR;
          end else if (grant_ls) begin
            owner_if_q <= 1'b0;
            addr_q     <= ls_addr_i;
            we_q       <= ls_we_i;
            len_q      <= 8'd0;
            size_q     <= ls_size_i;
            wdata_q    <= ls_wdata_i;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (m_addr_ready_i) begin
            cnt_q   <= 8'd0;
            state_q <= we_q ? WDATA : RDATA;
          end
        end
        WDATA: begin
          if (m_wready_i) state_q <= WRESP;
        end
        // The master drops addr_ready while it still owes the write
        // response; the first ready cycle means the store has retired.
        WRESP: begin
          if (m_addr_ready_i) state_q <= IDLE;
        end
        RDATA: begin
          if (m_rvalid_i) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == len_q) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ready_o     = grant_if;
  assign ls_ready_o     = grant_ls;

  assign m_addr_valid_o = (state_q == ADDR);
  assign m_wvalid_o     = (state_q == WDATA);
  assign m_rready_o     = (state_q == RDATA);
  assign m_addr_o       = addr_q;
  assign m_we_o         = we_q;
  assign m_len_o        = len_q;
  assign m_size_o       = size_q;
  assign m_burst_o      = 2'b01;
  assign m_wdata_o      = wdata_q;

  // Read beats go straight through to the owner; data is zeroed when not
  // valid so idle/reset outputs stay at 0 whatever the master drives.
  assign if_rvalid_o = beat & owner_if_q;
  assign if_rdata_o  = if_rvalid_o ? m_rdata_i : 64'd0;
  assign ls_rd_done  = beat & ~owner_if_q;
  assign ls_done_o   = ls_rd_done | ((state_q == WRESP) & m_addr_ready_i);
  assign ls_rdata_o  = ls_rd_done ? m_rdata_i : 64'd0;

endmodule
